// File: rtl/window_buffer_pkg.sv
// Shared vision-pipeline package: default pixel width, window-size legality
// and the flattened grid slot mapping used by window_buffer.
`default_nettype none

package pkg_vision;

  localparam int C_DATA_W_DEFAULT = 24;
  localparam int C_WIN_MIN        = 3;
  localparam int C_WIN_MAX        = 7;

  function automatic bit win_size_legal(input int k);
    return (k >= C_WIN_MIN) && (k <= C_WIN_MAX) && ((k % 2) == 1);
  endfunction

  // Slot index of window cell (i,j); i=0 oldest row, j=0 leftmost column.
  function automatic int slot_offset(input int i, input int j, input int k);
    return ((k - 1 - i) * k) + (k - 1 - j);
  endfunction

endpackage

`default_nettype wire

// File: rtl/window_buffer_if.sv
// Pixel-stream in / window-out bundle for window_buffer.
`default_nettype none

interface window_buffer_if
  import pkg_vision::*;
#(
  parameter int P_DATA_W = C_DATA_W_DEFAULT,
  parameter int P_WIN    = 5,
  parameter int P_X_W    = 10,
  parameter int P_Y_W    = 10
) ();

  logic                              sof;
  logic                              pix_valid;
  logic [P_DATA_W-1:0]               pix_data;
  logic                              win_valid;
  logic [P_X_W-1:0]                  win_x;
  logic [P_Y_W-1:0]                  win_y;
  logic [P_DATA_W*P_WIN*P_WIN-1:0]   oGrid;

  modport master (
    output sof, pix_valid, pix_data,
    input  win_valid, win_x, win_y, oGrid
  );

  modport slave (
    input  sof, pix_valid, pix_data,
    output win_valid, win_x, win_y, oGrid
  );

endinterface

`default_nettype wire

// File: rtl/window_buffer_line_mem.sv
// K-1 cascaded line RAMs sharing one column address; tap[k-1] returns the
// pixel written k lines earlier at the same column (read-before-write).
`default_nettype none

module window_line_mem #(
  parameter int P_DATA_W = 24,
  parameter int P_WIN    = 5,
  parameter int P_LINE_W = 640,
  parameter int P_X_W    = 10
) (
  input  wire logic                            clk,
  input  wire logic                            we,
  input  wire logic [P_X_W-1:0]                addr,
  input  wire logic [P_DATA_W-1:0]             din,
  output      logic [P_WIN-2:0][P_DATA_W-1:0]  tap
);

  for (genvar gk = 0; gk < P_WIN - 1; gk++) begin : g_line
    logic [P_DATA_W-1:0] r_mem [P_LINE_W];
    logic [P_DATA_W-1:0] w_wdata;

    // Each line is fed by the read of the line above it, so the cascade
    // ages one line per pass without extra shift logic.
    if (gk == 0) begin : g_first
      assign w_wdata = din;
    end else begin : g_chain
      assign w_wdata = tap[gk-1];
    end

    always_ff @(posedge clk) begin
      if (we) begin
        r_mem[addr] <= w_wdata;
      end
    end

    assign tap[gk] = r_mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/window_buffer.sv
// K x K sliding-window line buffer with column/row tracking, window validity
// gating and frame-start resynchronisation.
`default_nettype none

module window_buffer
  import pkg_vision::*;
#(
  parameter int P_DATA_W = C_DATA_W_DEFAULT,
  parameter int P_WIN    = 5,
  parameter int P_LINE_W = 640,
  parameter int P_X_W    = 10,
  parameter int P_Y_W    = 10
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  window_buffer_if.slave   bus
);

  if (!win_size_legal(P_WIN)) begin : g_bad_win
    $error("window_buffer: P_WIN must be odd and within 3..7");
  end

  localparam logic [P_X_W-1:0] C_LAST_COL  = P_X_W'(P_LINE_W - 1);
  localparam logic [P_Y_W-1:0] C_MAX_ROW   = '1;
  localparam logic [P_X_W-1:0] C_VALID_COL = P_X_W'(P_WIN - 1);
  localparam logic [P_Y_W-1:0] C_VALID_ROW = P_Y_W'(P_WIN - 1);

  logic [P_X_W-1:0]                              r_col;
  logic [P_Y_W-1:0]                              r_row;
  logic [P_X_W-1:0]                              w_col;
  logic [P_Y_W-1:0]                              w_row;
  logic [P_WIN-2:0][P_DATA_W-1:0]                w_tap;
  logic [P_WIN-1:0][P_DATA_W-1:0]                w_column;
  logic [P_WIN-1:0][P_WIN-1:0][P_DATA_W-1:0]     r_win;
  logic                                          r_win_valid;
  logic [P_X_W-1:0]                              r_win_x;
  logic [P_Y_W-1:0]                              r_win_y;

  // A pixel arriving with sof is coordinate (0,0) regardless of the counters.
  assign w_col = bus.sof ? '0 : r_col;
  assign w_row = bus.sof ? '0 : r_row;

  window_line_mem #(
    .P_DATA_W (P_DATA_W),
    .P_WIN    (P_WIN),
    .P_LINE_W (P_LINE_W),
    .P_X_W    (P_X_W)
  ) u_line_mem (
    .clk  (clk),
    .we   (bus.pix_valid),
    .addr (w_col),
    .din  (bus.pix_data),
    .tap  (w_tap)
  );

  for (genvar gi = 0; gi < P_WIN; gi++) begin : g_column
    if (gi == P_WIN - 1) begin : g_newest
      assign w_column[gi] = bus.pix_data;
    end else begin : g_older
      assign w_column[gi] = w_tap[P_WIN-2-gi];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.pix_valid) begin
      if (w_col == C_LAST_COL) begin
        r_col <= '0;
        r_row <= (w_row == C_MAX_ROW) ? w_row : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end else if (bus.sof) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // Wrap artefacts in the horizontal shift are left in place; the
  // row/column thresholds on win_valid keep them from ever being flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_win_x     <= '0;
      r_win_y     <= '0;
    end else begin
      r_win_valid <= bus.pix_valid && (w_row >= C_VALID_ROW) && (w_col >= C_VALID_COL);
      if (bus.pix_valid) begin
        r_win_x <= w_col;
        r_win_y <= w_row;
        for (int i = 0; i < P_WIN; i++) begin
          for (int j = 0; j < P_WIN - 1; j++) begin
            r_win[i][j] <= r_win[i][j+1];
          end
          r_win[i][P_WIN-1] <= w_column[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < P_WIN; gi++) begin : g_grid_row
    for (genvar gj = 0; gj < P_WIN; gj++) begin : g_grid_col
      assign bus.oGrid[slot_offset(gi, gj, P_WIN)*P_DATA_W +: P_DATA_W] = r_win[gi][gj];
    end
  end

  assign bus.win_valid = r_win_valid;
  assign bus.win_x     = r_win_x;
  assign bus.win_y     = r_win_y;

endmodule

`default_nettype wire

// File: tb/tb_window_buffer.sv
// Bench for window_buffer (3x3 window, 8-pixel lines, 8-bit pixels) against
// an image-array reference model.
`default_nettype none

module tb_window_buffer;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   failed;

  window_buffer_if #(.P_DATA_W(8), .P_WIN(3), .P_X_W(3), .P_Y_W(4)) bus ();

  window_buffer #(
    .P_DATA_W (8),
    .P_WIN    (3),
    .P_LINE_W (8),
    .P_X_W    (3),
    .P_Y_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the current frame as an image plus the raster position.
  logic [7:0]  img [0:15][0:7];
  int          mr;
  int          mc;
  logic        exp_valid;
  logic [2:0]  exp_x;
  logic [3:0]  exp_y;
  logic [71:0] exp_grid;
  bit          grid_known;

  function automatic logic [71:0] model_grid(input int r, input int c);
    logic [71:0] g;
    g = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        g[((2 - i) * 3 + (2 - j)) * 8 +: 8] = img[r - 2 + i][c - 2 + j];
    return g;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_valid = 1'b0; exp_x = '0; exp_y = '0;
    exp_grid = '0; grid_known = 1'b1;
  endtask

  task automatic drive(input bit s, input bit v, input logic [7:0] d);
    bus.sof = s; bus.pix_valid = v; bus.pix_data = d;
    @(posedge clk);
    #1;
    if (s) begin mr = 0; mc = 0; end
    if (v) begin
      img[mr][mc] = d;
      exp_valid  = (mr >= 2) && (mc >= 2);
      exp_x      = 3'(mc);
      exp_y      = 4'(mr);
      grid_known = exp_valid;
      if (exp_valid) exp_grid = model_grid(mr, mc);
      if (mc == 7) begin mc = 0; if (mr != 15) mr = mr + 1; end
      else mc = mc + 1;
    end else begin
      exp_valid = 1'b0;
    end
    bus.sof = 1'b0; bus.pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.win_valid !== 1'b0 || bus.win_x !== 3'd0 || bus.win_y !== 4'd0 || bus.oGrid !== 72'd0) begin
      failed++;
      $display("FAIL reset_initial: valid=%b x=%0d y=%0d grid=%h, required all zero", bus.win_valid, bus.win_x, bus.win_y, bus.oGrid);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) drive(1'b0, 1'b1, 8'((k / 8) * 16 + (k % 8)));
    bus.pix_valid = 1'b1; bus.pix_data = 8'h5A;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.win_valid !== 1'b0 || bus.win_x !== 3'd0 || bus.win_y !== 4'd0 || bus.oGrid !== 72'd0) begin
      failed++;
      $display("FAIL reset_async: valid=%b x=%0d y=%0d grid=%h, required all zero", bus.win_valid, bus.win_x, bus.win_y, bus.oGrid);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.win_valid !== 1'b0 || bus.win_x !== 3'd0 || bus.win_y !== 4'd0 || bus.oGrid !== 72'd0) begin
      failed++;
      $display("FAIL reset_held: valid=%b x=%0d y=%0d grid=%h, required all zero", bus.win_valid, bus.win_x, bus.win_y, bus.oGrid);
    end
    bus.pix_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 8'h00);
    tests_run++;
    if (bus.win_valid !== 1'b0 || bus.win_x !== 3'd0 || bus.win_y !== 4'd0) begin
      failed++;
      $display("FAIL reset_first_pixel: valid=%b x=%0d y=%0d, required 0 0 0", bus.win_valid, bus.win_x, bus.win_y);
    end
  endtask

  task automatic test_full_frame();
    int nvalid = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        drive(r == 0 && c == 0, 1'b1, 8'(r * 16 + c));
        tests_run++;
        if (bus.win_valid !== exp_valid || bus.win_x !== exp_x || bus.win_y !== exp_y) begin
          failed++;
          $display("FAIL full_frame_ctl (%0d,%0d): valid/x/y=%b/%0d/%0d required %b/%0d/%0d", r, c, bus.win_valid, bus.win_x, bus.win_y, exp_valid, exp_x, exp_y);
        end
        if (grid_known) begin
          tests_run++;
          if (bus.oGrid !== exp_grid) begin
            failed++;
            $display("FAIL full_frame_grid (%0d,%0d): got %h required %h", r, c, bus.oGrid, exp_grid);
          end
        end
        if (bus.win_valid === 1'b1) nvalid++;
        if (r == 2 && c == 2) begin
          tests_run++;
          if (bus.oGrid[71:64] !== 8'h00 || bus.oGrid[39:32] !== 8'h11 || bus.oGrid[7:0] !== 8'h22) begin
            failed++;
            $display("FAIL full_frame_2_2: tl/centre/lsb=%h/%h/%h required 00/11/22", bus.oGrid[71:64], bus.oGrid[39:32], bus.oGrid[7:0]);
          end
        end
      end
    end
    tests_run++;
    if (nvalid != 36) begin
      failed++;
      $display("FAIL full_frame_count: %0d valid windows, required 36", nvalid);
    end
  endtask

  task automatic test_line_wrap();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (r == 4 && c > 2) break;
        drive(r == 0 && c == 0, 1'b1, 8'(r * 16 + c));
        tests_run++;
        if (bus.win_valid !== exp_valid || bus.win_x !== exp_x || bus.win_y !== exp_y ||
            (grid_known && bus.oGrid !== exp_grid)) begin
          failed++;
          $display("FAIL wrap_model (%0d,%0d): valid=%b grid=%h required %b %h", r, c, bus.win_valid, bus.oGrid, exp_valid, exp_grid);
        end
        if ((r == 3 && c == 7) || (r == 4 && c == 2)) begin
          tests_run++;
          if (bus.win_valid !== 1'b1 || bus.oGrid[71:64] !== ((r == 3) ? 8'h15 : 8'h20)) begin
            failed++;
            $display("FAIL wrap_edge (%0d,%0d): valid=%b tl=%h required 1 %h", r, c, bus.win_valid, bus.oGrid[71:64], (r == 3) ? 8'h15 : 8'h20);
          end
        end
        if (r == 4 && c == 0) begin
          tests_run++;
          if (bus.win_valid !== 1'b0) begin
            failed++;
            $display("FAIL wrap_4_0: valid=%b required 0", bus.win_valid);
          end
        end
      end
    end
  endtask

  task automatic test_bubbles();
    int nvalid = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        while ($urandom_range(1, 0) == 0) begin
          drive(1'b0, 1'b0, 8'($urandom));
          tests_run++;
          if (bus.win_valid !== 1'b0 || bus.win_x !== exp_x || bus.win_y !== exp_y ||
              (grid_known && bus.oGrid !== exp_grid)) begin
            failed++;
            $display("FAIL bubble_gap (%0d,%0d): valid=%b x=%0d y=%0d grid=%h required 0 %0d %0d %h", r, c, bus.win_valid, bus.win_x, bus.win_y, bus.oGrid, exp_x, exp_y, exp_grid);
          end
        end
        drive(r == 0 && c == 0, 1'b1, 8'(r * 16 + c));
        tests_run++;
        if (bus.win_valid !== exp_valid || bus.win_x !== exp_x || bus.win_y !== exp_y ||
            (grid_known && bus.oGrid !== exp_grid)) begin
          failed++;
          $display("FAIL bubble_pixel (%0d,%0d): valid=%b grid=%h required %b %h", r, c, bus.win_valid, bus.oGrid, exp_valid, exp_grid);
        end
        if (bus.win_valid === 1'b1) nvalid++;
      end
    end
    tests_run++;
    if (nvalid != 36) begin
      failed++;
      $display("FAIL bubble_count: %0d valid windows, required 36", nvalid);
    end
  endtask

  task automatic test_midframe_sof();
    for (int k = 0; k < 28; k++) drive(k == 0, 1'b1, 8'((k / 8) * 16 + (k % 8)));
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        drive(r == 0 && c == 0, 1'b1, 8'(8'hA0 + r * 16 + c));
        tests_run++;
        if (bus.win_valid !== exp_valid || bus.win_x !== exp_x || bus.win_y !== exp_y ||
            (grid_known && bus.oGrid !== exp_grid) || (r < 2 && bus.win_valid !== 1'b0)) begin
          failed++;
          $display("FAIL midsof (%0d,%0d): valid=%b x=%0d y=%0d grid=%h required %b %0d %0d %h", r, c, bus.win_valid, bus.win_x, bus.win_y, bus.oGrid, exp_valid, exp_x, exp_y, exp_grid);
        end
        if (r == 2 && c == 2) begin
          bit stale = 1'b0;
          for (int s = 0; s < 9; s++) if (bus.oGrid[s*8 +: 8] < 8'hA0) stale = 1'b1;
          tests_run++;
          if (bus.win_valid !== 1'b1 || stale) begin
            failed++;
            $display("FAIL midsof_first_window: valid=%b grid=%h required 1 with only new-frame values", bus.win_valid, bus.oGrid);
          end
        end
      end
    end
  endtask

  task automatic test_sof_gap();
    for (int k = 0; k < 13; k++) drive(k == 0, 1'b1, 8'((k / 8) * 16 + (k % 8)));
    drive(1'b1, 1'b0, 8'h77);
    tests_run++;
    if (bus.win_valid !== 1'b0) begin
      failed++;
      $display("FAIL sofgap_idle: valid=%b required 0", bus.win_valid);
    end
    repeat (3) drive(1'b0, 1'b0, 8'($urandom));
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) begin
        drive(1'b0, 1'b1, 8'(r * 16 + c));
        tests_run++;
        if (bus.win_valid !== exp_valid || bus.win_x !== exp_x || bus.win_y !== exp_y ||
            (grid_known && bus.oGrid !== exp_grid) || ((r < 2 || c < 2) && bus.win_valid !== 1'b0)) begin
          failed++;
          $display("FAIL sofgap (%0d,%0d): valid=%b x=%0d y=%0d required %b %0d %0d", r, c, bus.win_valid, bus.win_x, bus.win_y, exp_valid, exp_x, exp_y);
        end
        if (r == 0 && c == 0) begin
          tests_run++;
          if (bus.win_x !== 3'd0 || bus.win_y !== 4'd0) begin
            failed++;
            $display("FAIL sofgap_restart: x=%0d y=%0d required 0 0", bus.win_x, bus.win_y);
          end
        end
      end
    end
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    rst_n = 1'b0;
    bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_full_frame();
    test_line_wrap();
    test_bubbles();
    test_midframe_sof();
    test_sof_gap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/window_buffer.md
Name: window_buffer

Overview:
- Parametrised K×K sliding-window line buffer for the edge-detection pipeline. Generalises the fixed 5×5 buffer in window size, line length and pixel width.
- Accepts one raster-order pixel per `pix_valid` and keeps K-1 previous lines in internal line memory.
- Presents the full K×K neighbourhood every accepted pixel.
- Adds what the 5×5 version lacked: column/row tracking, a `win_valid` flag that suppresses windows containing line-wrap or stale data, frame-start resynchronisation, and coordinates of the newest pixel.

Parameters:
- P_DATA_W, 24, bits per pixel (RGB or intensity).
- P_WIN, 5, window size K; odd, legal range 3..7.
- P_LINE_W, 640, pixels per line; sets line-memory depth.
- P_X_W, 10, width of column counter; must satisfy 2^P_X_W >= P_LINE_W.
- P_Y_W, 10, width of row counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sof  in  1  start of frame; restarts counters; may coincide with pix_valid.
- pix_valid  in  1  pix_data accepted this cycle (clock enable).
- pix_data  in  P_DATA_W  incoming pixel, raster order.
- win_valid  out  1  oGrid holds a complete in-image window.
- win_x  out  P_X_W  column of newest pixel in window.
- win_y  out  P_Y_W  row of newest pixel in window.
- oGrid  out  P_DATA_W*P_WIN*P_WIN  flattened window.

Behaviour:
- Reset (rst_n low, async): win_valid=0, win_x=0, win_y=0, oGrid=0, col=0, row=0. Line-memory contents are don't-care.
- Internal counters:
  - col runs 0..P_LINE_W-1.
  - row increments when col wraps and saturates at 2^P_Y_W-1.
- Accept: on a clk edge with pix_valid=1, pixel p(row,col) is written to line memory and shifted into the window.
- Latency: 1 cycle. The cycle after acceptance, oGrid holds rows row-K+1..row and cols col-K+1..col.
- Grid ordering: slot (i,j) sits at bit offset ((K-1-i)*K+(K-1-j))*P_DATA_W.
  - i=0 is the oldest row; j=0 is the leftmost column.
  - The MSB slot is top-left; the LSB slot is the newest pixel.
- Output update: win_x/win_y are registered with the window and equal the (col,row) of the accepted pixel.
- win_valid registered = pix_valid && row>=K-1 && col>=K-1, evaluated on the accepted pixel. It is therefore 0 for the first K-1 rows and the first K-1 columns of each row, so windows straddling a line wrap are never flagged valid.
- pix_valid=0: window, win_x, win_y and counters hold; win_valid goes 0 the next cycle.
- Line wrap: accepting col=P_LINE_W-1 sets col=0 and row=row+1 (saturating). The horizontal shift registers are not cleared; the validity gating covers wrap artefacts.
- sof without pix_valid: col=0, row=0 next cycle; win_valid=0; the next accepted pixel is (0,0).
- sof with pix_valid: that pixel is treated as (0,0) and win_valid=0 for it.
- Mid-frame sof: always honoured. Old line-memory data is never exposed, because row<K-1 gates win_valid until K-1 fresh lines are written. No RAM clear is needed.
- Line memory: K-1 lines, depth P_LINE_W, addressed by col, read-before-write.
  - The tap for row offset k returns the pixel written k lines earlier at the same column.
  - The read happens in the same enable cycle; a synchronous-read RAM must compensate internally so the 1-cycle latency above still holds.

Decomposition:
- Shared package pkg_vision holds:
  - P_DATA_W default;
  - the legal-range check constant for P_WIN;
  - the grid index function slot_offset(i,j,K).
- One sub-module, window_line_mem: K-1 parallel line RAMs with a single col address, write enable = pix_valid, outputs tap[1..K-1].
- Top level holds the counters, the K×K shift registers, validity and coordinate registers.

Test Plan:
All scenarios use P_WIN=3, P_LINE_W=8, P_DATA_W=8, P_X_W=3, P_Y_W=4, pixel value = row*16+col.

1. Reset: assert rst_n low mid-stream with pix_valid=1 -> win_valid=0, win_x=0, win_y=0, oGrid=0 immediately; pixel after release is (0,0).
2. Full frame, continuous valid -> win_valid=1 exactly for row>=2, col>=2 (6 per row from row 2). At pixel (2,2): oGrid top-left=0x00, centre=0x11, LSB slot=0x22.
3. Line wrap: check the windows at (3,7) and (4,0) -> (3,7) valid, grid top-left=0x15; (4,0) win_valid=0; (4,2) valid, top-left=0x20.
4. Bubbles: random pix_valid duty 50% -> every valid window is identical to scenario 2; outputs hold during gaps; win_valid=0 on each gap cycle.
5. Mid-frame sof with pix_valid at (3,4), new data value 0xA0+... -> win_valid=0 for new rows 0-1; first valid window at new (2,2) contains only new-frame values.
6. sof without pix_valid between frames, then restart -> win_x/win_y restart at 0; no window flagged valid before new (2,2).
